// File: rtl/piano_pkg.sv
// Shared constants, FSM encoding and ROM word field helpers for the note sequencer.
package piano_pkg;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 4;
    localparam int ADDR_W = 8;
    localparam int ROM_W  = DUR_W + NOTE_W;

    localparam logic [NOTE_W-1:0] REST_CODE = '0;
    localparam logic [DUR_W-1:0]  END_DUR   = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_DONE
    } state_e;

    // ROM word layout is {dur, note}
    function automatic logic [DUR_W-1:0] rom_dur(input logic [ROM_W-1:0] w);
        return w[ROM_W-1 -: DUR_W];
    endfunction

    function automatic logic [NOTE_W-1:0] rom_note(input logic [ROM_W-1:0] w);
        return w[NOTE_W-1:0];
    endfunction
endpackage

// File: rtl/beat_note_sequencer_if.sv
// Control, song ROM and tone-generator signals of the beat note sequencer.
interface beat_note_sequencer_if;
    import piano_pkg::*;

    logic              beat_tick;
    logic              play;
    logic              pause;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [ROM_W-1:0]  rom_data;
    logic [NOTE_W-1:0] note_code;
    logic              note_on;
    logic              busy;
    logic              done;

    modport slave (
        input  beat_tick, play, pause, stop, loop_en, rom_data,
        output rom_addr, note_code, note_on, busy, done
    );

    modport master (
        output beat_tick, play, pause, stop, loop_en, rom_data,
        input  rom_addr, note_code, note_on, busy, done
    );
endinterface

// File: rtl/beat_note_sequencer.sv
// Steps through {dur, note} entries of an external sync song ROM, holding each note
// for dur beat ticks; supports play/pause/stop/loop and reports end of song.
module beat_note_sequencer
    import piano_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    beat_note_sequencer_if.slave  bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              on_q, on_d;
    logic [DUR_W-1:0]  beats_q, beats_d;
    logic              done_d;
    logic              at_end;
    logic [DUR_W-1:0]  dur;
    logic [NOTE_W-1:0] note;

    assign dur  = rom_dur(bus.rom_data);
    assign note = rom_note(bus.rom_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            note_q  <= REST_CODE;
            on_q    <= 1'b0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            on_q    <= on_d;
            beats_q <= beats_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        note_d  = note_q;
        on_d    = on_q;
        beats_d = beats_q;
        done_d  = 1'b0;
        at_end  = 1'b0;
        if (bus.stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
            note_d  = REST_CODE;
            on_d    = 1'b0;
            beats_d = '0;
        end else if (bus.play) begin
            // current note keeps sounding until the restarted song's first entry loads
            addr_d  = '0;
            state_d = S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    if (dur == END_DUR) begin
                        at_end = 1'b1;
                    end else begin
                        note_d  = note;
                        on_d    = (note != REST_CODE);
                        beats_d = dur;
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (bus.beat_tick && !bus.pause) begin
                        beats_d = beats_q - 1'b1;
                        if (beats_q == 1) begin
                            if (addr_q == '1) begin
                                at_end = 1'b1;
                            end else begin
                                addr_d  = addr_q + 1'b1;
                                state_d = S_FETCH;
                            end
                        end
                    end
                end
                default: ;
            endcase
            // end marker or top of ROM: loop back or finish silently
            if (at_end) begin
                if (bus.loop_en) begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    note_d  = REST_CODE;
                    on_d    = 1'b0;
                end
            end
        end
    end

    assign bus.rom_addr  = addr_q;
    assign bus.note_code = note_q;
    assign bus.note_on   = on_q && !(state_q == S_PLAY && bus.pause);
    assign bus.busy      = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_PLAY);
    assign bus.done      = done_d;
endmodule

// File: tb/tb_beat_note_sequencer.sv
// Directed and randomized checks of beat_note_sequencer against a song-walking reference model.
module tb_beat_note_sequencer;
    import piano_pkg::*;

    localparam int TOP = (1 << ADDR_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    beat_note_sequencer_if bus();

    beat_note_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [ROM_W-1:0] rom_mem [1 << ADDR_W];
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    int done_cnt = 0;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt = done_cnt + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Walk the song: n effective ticks after play lands on which entry?
    function automatic void model(input int n, input bit lp, output int note, output bit on,
                                  output bit ended, output int addr);
        int a, t, d;
        a = 0; t = n; ended = 1'b0; note = 0; on = 1'b0; addr = 0;
        for (int g = 0; g < 8192; g++) begin
            d = int'(rom_mem[a][ROM_W-1 -: DUR_W]);
            if (d != 0 && t < d) begin
                note = int'(rom_mem[a][NOTE_W-1:0]);
                on   = (note != 0);
                addr = a;
                return;
            end
            if (d != 0) t -= d;
            if (d == 0 || a == TOP) begin
                if (lp) a = 0;
                else begin
                    ended = 1'b1;
                    addr  = a;
                    return;
                end
            end else begin
                a++;
            end
        end
    endfunction

    task automatic chk_model(input string tag, input int n, input bit lp);
        int en, ea;
        bit eo, ee;
        model(n, lp, en, eo, ee, ea);
        chk({tag, ".note"}, int'(bus.note_code), en);
        chk({tag, ".on"},   int'(bus.note_on), int'(eo));
        chk({tag, ".busy"}, int'(bus.busy), int'(!ee));
        chk({tag, ".addr"}, int'(bus.rom_addr), ea);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick;
        bus.beat_tick = 1'b1; @(negedge clk); bus.beat_tick = 1'b0;
    endtask

    task automatic do_play;
        bus.play = 1'b1; @(negedge clk); bus.play = 1'b0;
    endtask

    task automatic do_stop;
        bus.stop = 1'b1; @(negedge clk); bus.stop = 1'b0;
    endtask

    task automatic clear_rom;
        for (int i = 0; i <= TOP; i++) rom_mem[i] = '0;
    endtask

    task automatic load_song1;
        clear_rom();
        rom_mem[0] = {4'd2, 6'd5};
        rom_mem[1] = {4'd1, 6'd0};
        rom_mem[2] = {4'd3, 6'd9};
        rom_mem[3] = {4'd0, 6'd33};
    endtask

    initial begin
        int d0, len, total, nt;
        bit lp;
        bus.beat_tick = 1'b0; bus.play = 1'b0; bus.pause = 1'b0;
        bus.stop = 1'b0; bus.loop_en = 1'b0;
        clear_rom();
        rst = 1'b1;
        step(2);
        chk("rst.addr", int'(bus.rom_addr), 0);
        chk("rst.note", int'(bus.note_code), 0);
        chk("rst.on",   int'(bus.note_on), 0);
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.done", int'(bus.done), 0);
        rst = 1'b0;
        step(2);

        // song plays once then ends with a single done pulse
        load_song1();
        d0 = done_cnt;
        do_play(); step(2);
        chk("t1.lat.note", int'(bus.note_code), 5);
        chk("t1.lat.on",   int'(bus.note_on), 1);
        for (int k = 1; k <= 6; k++) begin
            do_tick(); step(19);
            chk_model($sformatf("t1.k%0d", k), k, 1'b0);
        end
        chk("t1.done_cnt", done_cnt - d0, 1);

        // looping: end marker returns to address 0, done never pulses
        bus.loop_en = 1'b1;
        d0 = done_cnt;
        do_play(); step(5);
        for (int k = 1; k <= 9; k++) begin
            do_tick(); step(19);
            chk_model($sformatf("t2.k%0d", k), k, 1'b1);
        end
        chk("t2.done_cnt", done_cnt - d0, 0);
        bus.loop_en = 1'b0;
        do_stop(); step(2);

        // pause in the middle of note 9
        d0 = done_cnt;
        do_play(); step(5);
        for (int k = 1; k <= 4; k++) begin do_tick(); step(9); end
        chk_model("t3.pre", 4, 1'b0);
        bus.pause = 1'b1;
        step(1);
        for (int k = 0; k < 5; k++) begin
            do_tick(); step(9);
            chk($sformatf("t3.p%0d.on", k),   int'(bus.note_on), 0);
            chk($sformatf("t3.p%0d.note", k), int'(bus.note_code), 9);
            chk($sformatf("t3.p%0d.addr", k), int'(bus.rom_addr), 2);
        end
        bus.pause = 1'b0;
        step(1);
        chk("t3.rel.on", int'(bus.note_on), 1);
        for (int k = 5; k <= 6; k++) begin
            do_tick(); step(9);
            chk_model($sformatf("t3.k%0d", k), k, 1'b0);
        end
        chk("t3.done_cnt", done_cnt - d0, 1);

        // stop coincident with a tick in PLAY
        do_play(); step(5);
        do_tick(); step(9);
        bus.stop = 1'b1; bus.beat_tick = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0; bus.beat_tick = 1'b0;
        chk("t4.busy", int'(bus.busy), 0);
        chk("t4.on",   int'(bus.note_on), 0);
        chk("t4.note", int'(bus.note_code), 0);
        chk("t4.addr", int'(bus.rom_addr), 0);
        for (int k = 0; k < 2; k++) begin do_tick(); step(9); end
        chk("t4.idle.busy", int'(bus.busy), 0);
        chk("t4.idle.addr", int'(bus.rom_addr), 0);

        // play during the second note restarts the song
        do_play(); step(5);
        for (int k = 1; k <= 2; k++) begin do_tick(); step(9); end
        chk_model("t5.pre", 2, 1'b0);
        do_play(); step(2);
        chk("t5.note", int'(bus.note_code), 5);
        chk("t5.on",   int'(bus.note_on), 1);
        chk("t5.addr", int'(bus.rom_addr), 0);
        do_tick(); step(9);
        chk_model("t5.k1", 1, 1'b0);

        // asynchronous reset while in LOAD
        do_play(); step(5);
        do_tick(); step(9);
        do_tick(); step(1);
        chk("t6.load.busy", int'(bus.busy), 1);
        chk("t6.load.note", int'(bus.note_code), 5);
        rst = 1'b1;
        #1;
        chk("t6.rst.note", int'(bus.note_code), 0);
        chk("t6.rst.on",   int'(bus.note_on), 0);
        chk("t6.rst.addr", int'(bus.rom_addr), 0);
        chk("t6.rst.busy", int'(bus.busy), 0);
        chk("t6.rst.done", int'(bus.done), 0);
        step(2);
        rst = 1'b0;
        step(2);

        // full ROM of one-beat notes: the top address ends the song, no wrap
        for (int i = 0; i <= TOP; i++) rom_mem[i] = {4'd1, 6'($urandom_range(1, 63))};
        d0 = done_cnt;
        do_play(); step(5);
        for (int k = 1; k <= TOP + 1; k++) begin
            do_tick(); step(7);
            if (k % 64 == 0 || k >= TOP) chk_model($sformatf("t7.k%0d", k), k, 1'b0);
        end
        chk("t7.done_cnt", done_cnt - d0, 1);
        chk("t7.addr", int'(bus.rom_addr), TOP);

        // randomized songs with random tick spacing and loop setting
        for (int s = 0; s < 6; s++) begin
            clear_rom();
            len = $urandom_range(2, 6);
            total = 0;
            for (int i = 0; i < len; i++) begin
                rom_mem[i] = {4'($urandom_range(1, 3)), 6'($urandom_range(0, 63))};
                total += int'(rom_mem[i][ROM_W-1 -: DUR_W]);
            end
            lp = 1'($urandom_range(0, 1));
            bus.loop_en = lp;
            nt = total + $urandom_range(0, 4);
            d0 = done_cnt;
            do_play(); step(5);
            for (int k = 1; k <= nt; k++) begin
                do_tick(); step($urandom_range(6, 15));
                chk_model($sformatf("r%0d.k%0d", s, k), k, lp);
            end
            chk($sformatf("r%0d.done_cnt", s), done_cnt - d0, (!lp && nt >= total) ? 1 : 0);
            do_stop(); step(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
